// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode display with frame snapshots.
// Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_scanner #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] digits_i,
  input  logic [3:0]  dp_mask_i,
  input  logic        overflow_i,
  output logic [3:0]  an_o,
  output logic [6:0]  bcd_o,
  output logic        dp_o
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic [15:0]      r_snap_digits;
  logic [3:0]       r_snap_dp;
  logic             r_snap_ovf;
  logic [3:0]       r_an;
  logic [6:0]       r_bcd;
  logic             r_dp;

  logic             w_tick;
  logic             w_new_frame;
  logic [1:0]       w_next_idx;
  logic [15:0]      w_frame_digits;
  logic [3:0]       w_frame_dp;
  logic             w_frame_ovf;
  logic [6:0]       w_seg [4];
  logic [3:0]       w_blank;
  logic             w_slot_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_DASH;
    endcase
  endfunction

  assign w_tick      = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_next_idx  = r_idx + 2'd1;
  assign w_new_frame = w_tick && (r_idx == 2'd3);

  // Digit 0 of a new frame is latched on the same edge as the snapshot, so
  // decode straight from the inputs on that edge to keep the frame coherent.
  assign w_frame_digits = w_new_frame ? digits_i   : r_snap_digits;
  assign w_frame_dp     = w_new_frame ? dp_mask_i  : r_snap_dp;
  assign w_frame_ovf    = w_new_frame ? overflow_i : r_snap_ovf;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_decode
      assign w_seg[gi] = seg_decode(w_frame_digits[4*gi +: 4]);
    end
  endgenerate

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // A digit blanks only if it and every digit above it is a dot-less zero.
  assign w_blank[3] = (w_frame_digits[15:12] == 4'd0) && !w_frame_dp[3];
  assign w_blank[2] = w_blank[3] && (w_frame_digits[11:8] == 4'd0) && !w_frame_dp[2];
  assign w_blank[1] = w_blank[2] && (w_frame_digits[7:4] == 4'd0) && !w_frame_dp[1];
  assign w_blank[0] = 1'b0;
`else
  assign w_blank = 4'b0000;
`endif

  assign w_slot_blank = w_blank[w_next_idx] && !w_frame_ovf;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div         <= '0;
      r_idx         <= 2'd3;
      r_snap_digits <= '0;
      r_snap_dp     <= '0;
      r_snap_ovf    <= 1'b0;
      r_an          <= 4'b1111;
      r_bcd         <= SEG_OFF;
      r_dp          <= 1'b1;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_idx <= w_next_idx;
        if (w_new_frame) begin
          r_snap_digits <= digits_i;
          r_snap_dp     <= dp_mask_i;
          r_snap_ovf    <= overflow_i;
        end
        if (w_slot_blank) begin
          r_an  <= 4'b1111;
          r_bcd <= SEG_OFF;
          r_dp  <= 1'b1;
        end else begin
          r_an  <= ~(4'b0001 << w_next_idx);
          r_bcd <= w_frame_ovf ? SEG_DASH : w_seg[w_next_idx];
          r_dp  <= w_frame_ovf ? 1'b1 : ~w_frame_dp[w_next_idx];
        end
      end
    end
  end

  assign an_o  = r_an;
  assign bcd_o = r_bcd;
  assign dp_o  = r_dp;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: expected slots are queued up front and a
// negedge monitor compares every cycle against the queue head.
module tb_seven_seg_scanner;

  localparam int SCAN_DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] digits_i = 16'h1234;
  logic [3:0]  dp_mask_i = 4'b0100;
  logic        overflow_i = 1'b0;
  logic [3:0]  an_o;
  logic [6:0]  bcd_o;
  logic        dp_o;

  typedef struct {
    logic [3:0] an;
    logic [6:0] bcd;
    logic       dp;
    int         cnt;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  seven_seg_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .digits_i(digits_i), .dp_mask_i(dp_mask_i),
    .overflow_i(overflow_i), .an_o(an_o), .bcd_o(bcd_o), .dp_o(dp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic push_raw(input logic [3:0] an, input logic [6:0] bcd, input logic dp,
                          input int cnt, input string name);
    exp_t e;
    e.an = an; e.bcd = bcd; e.dp = dp; e.cnt = cnt; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic push_slot(input int k, input logic [6:0] bcd, input logic dp,
                           input int cnt, input string name);
    logic [3:0] an;
    an = 4'b1111;
    an[k] = 1'b0;
    push_raw(an, bcd, dp, cnt, name);
  endtask

  task automatic push_blank(input int cnt, input string name);
    push_raw(4'b1111, OFF, 1'b1, cnt, name);
  endtask

  task automatic check(input string name, input logic [3:0] ea, input logic [6:0] eb,
                       input logic ed);
    n_vec++;
    if (an_o !== ea || bcd_o !== eb || dp_o !== ed) begin
      n_fail++;
      $display("FAIL %s: got an=%b bcd=%b dp=%b, want an=%b bcd=%b dp=%b",
               name, an_o, bcd_o, dp_o, ea, eb, ed);
    end else begin
      $display("ok   %s: an=%b bcd=%b dp=%b", name, an_o, bcd_o, dp_o);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Monitor: one comparison per cycle while out of reset.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && exp_q.size() != 0) begin
        check(exp_q[0].name, exp_q[0].an, exp_q[0].bcd, exp_q[0].dp);
        exp_q[0].cnt = exp_q[0].cnt - 1;
        if (exp_q[0].cnt == 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset phase then frame 0: 1234, dp on digit 2
    push_raw(4'b1111, OFF, 1'b1, 3, "reset_hold");
    push_slot(0, S4, 1'b1, SCAN_DIV, "f0_d0");
    push_slot(1, S3, 1'b1, SCAN_DIV, "f0_d1");
    push_slot(2, S2, 1'b0, SCAN_DIV, "f0_d2_tear");
    push_slot(3, S1, 1'b1, SCAN_DIV, "f0_d3_tear");
    // Frame 1: 5678 captured at the frame boundary
    push_slot(0, S8, 1'b1, SCAN_DIV, "f1_d0");
    push_slot(1, S7, 1'b1, SCAN_DIV, "f1_d1");
    push_slot(2, S6, 1'b0, SCAN_DIV, "f1_d2");
    push_slot(3, S5, 1'b1, SCAN_DIV, "f1_d3");
    // Frame 2: 00A0, no dots
    push_slot(0, S0, 1'b1, SCAN_DIV, "f2_d0");
    push_slot(1, DASH, 1'b1, SCAN_DIV, "f2_d1_invalid");
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    push_blank(SCAN_DIV, "f2_d2_blank");
    push_blank(SCAN_DIV, "f2_d3_blank");
`else
    push_slot(2, S0, 1'b1, SCAN_DIV, "f2_d2");
    push_slot(3, S0, 1'b1, SCAN_DIV, "f2_d3");
`endif
    // Frame 3: overflow with digits 1234 and all dots
    push_slot(0, DASH, 1'b1, SCAN_DIV, "f3_d0_ovf");
    push_slot(1, DASH, 1'b1, SCAN_DIV, "f3_d1_ovf");
    push_slot(2, DASH, 1'b1, SCAN_DIV, "f3_d2_ovf");
    push_slot(3, DASH, 1'b1, SCAN_DIV, "f3_d3_ovf");
    // Frame 4: 0045, no dots
    push_slot(0, S5, 1'b1, SCAN_DIV, "f4_d0");
    push_slot(1, S4, 1'b1, SCAN_DIV, "f4_d1");
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    push_blank(SCAN_DIV, "f4_d2_blank");
    push_blank(SCAN_DIV, "f4_d3_blank");
`else
    push_slot(2, S0, 1'b1, SCAN_DIV, "f4_d2");
    push_slot(3, S0, 1'b1, SCAN_DIV, "f4_d3");
`endif
    // Frame 5: 0005 with a dot on digit 1; reset lands two cycles into digit 2
    push_slot(0, S5, 1'b1, SCAN_DIV, "f5_d0");
    push_slot(1, S0, 1'b0, SCAN_DIV, "f5_d1_dot");
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    push_blank(2, "f5_d2_blank");
`else
    push_slot(2, S0, 1'b1, 2, "f5_d2");
`endif

    repeat (3) @(negedge clk_i);
    #1 rst_i = 1'b0;

    wait_edges(9);
    digits_i = 16'h5678;
    wait_edges(16);
    digits_i = 16'h00A0; dp_mask_i = 4'b0000;
    wait_edges(16);
    digits_i = 16'h1234; dp_mask_i = 4'b1111; overflow_i = 1'b1;
    wait_edges(16);
    digits_i = 16'h0045; dp_mask_i = 4'b0000; overflow_i = 1'b0;
    wait_edges(16);
    digits_i = 16'h0005; dp_mask_i = 4'b0010;
    wait_edges(20);

    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 check("async_reset", 4'b1111, OFF, 1'b1);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL pre_reset_drain: got %0d pending slots, want 0", exp_q.size());
    end

    digits_i = 16'h1234; dp_mask_i = 4'b0100; overflow_i = 1'b0;
    push_raw(4'b1111, OFF, 1'b1, 3, "rereset_hold");
    push_slot(0, S4, 1'b1, SCAN_DIV, "r_d0");
    push_slot(1, S3, 1'b1, SCAN_DIV, "r_d1");
    push_slot(2, S2, 1'b0, SCAN_DIV, "r_d2");
    push_slot(3, S1, 1'b1, SCAN_DIV, "r_d3");
    @(negedge clk_i);
    check("reset_held", 4'b1111, OFF, 1'b1);
    @(negedge clk_i);
    #1 rst_i = 1'b0;

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: got %0d pending slots, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Downstream display stage of the stopwatch: consumes the four BCD digits, decimal-point mask and overflow flag from the BCD incrementor chain.
- Drives the 4-digit common-anode 7-segment display on the board through time-multiplexed an_o/bcd_o/dp_o.
- Latches a whole frame of digits at a time, so a count change mid-scan never tears the display.

Parameters:
- SCAN_DIV, 100000, clocks per digit slot (1 kHz digit rate at 100 MHz); legal range >= 2; benches use 4.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, asynchronous, active-high
- digits_i  input  16  four BCD nibbles; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3
- dp_mask_i  input  4  bit k high = decimal point lit on digit k
- overflow_i  input  1  counter overflow flag; forces dash display
- an_o  output  4  anode enables, active-low; an_o[k]=0 selects digit k
- bcd_o  output  7  segment pattern, active-low; bit0=a ... bit6=g
- dp_o  output  1  decimal point, active-low

Behaviour:
- Reset (async, while rst_i=1):
  - an_o=4'b1111, bcd_o=7'b1111111, dp_o=1.
  - Divider=0, digit index=3, snapshot (digits, dp mask, overflow)=0.
- Divider:
  - Width $clog2(SCAN_DIV).
  - Increments every clock. On the edge where divider==SCAN_DIV-1 ("tick"), divider wraps to 0.
- Digit index:
  - 2-bit, advances on tick: 3->0->1->2->3.
  - After reset the first tick selects digit 0.
- Snapshot:
  - On a tick where the index goes 3->0, digits_i, dp_mask_i and overflow_i are captured into frame registers.
  - All four slots of the frame use only that snapshot.
- Outputs are registered and update on the tick edge itself:
  - The first output change after reset release occurs on the SCAN_DIV-th rising edge.
  - Each digit is then held exactly SCAN_DIV cycles.
  - Exactly one an_o bit is low at any time after the first tick.
- Decode, active-low {g,f,e,d,c,b,a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles A-F show a dash: 0111111.
- dp_o = ~snapshot_dp[index].
- Overflow: when snapshot overflow=1, every digit shows a dash and dp_o=1, regardless of digits and mask.
- Boundary conditions:
  - Inputs changing between snapshots have no effect until the next 3->0 tick.
  - Reset mid-slot immediately returns all outputs to the reset values. The scan restarts from the first-tick rule after release.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN
- Defined:
  - Leading zero digits are blanked: an_o bit stays 1, bcd_o=1111111, dp_o=1 for that slot.
  - A leading zero is any zero in digit 3, 2 or 1 with all higher digits also zero, and not carrying a decimal point.
  - Digit 0 is never blanked.
  - Overflow dashes override blanking.
- Undefined:
  - All four digits are always driven.
  - Slot timing is identical in both builds; only the slot contents differ.

Test Plan (SCAN_DIV=4):
- Reset:
  - Stimulus: hold rst_i, release.
  - Required: an_o=1111, bcd_o=1111111, dp_o=1 through the first 3 edges after release; at edge 4, an_o=1110.
- Static frame:
  - Stimulus: digits_i=16'h1234, dp_mask_i=4'b0100.
  - Required: an_o/bcd_o sequence 1110/0011001, 1101/0110000, 1011/0100100 with dp_o=0, 0111/1111001; each held 4 cycles; dp_o=1 in the other slots.
- Tearing:
  - Stimulus: change digits_i to 16'h5678 while digit 1 is shown.
  - Required: digits 2 and 3 of the current frame still show 2 and 1; the next frame shows 8,7,6,5.
- Invalid nibble and overflow:
  - Stimulus: digits_i=16'h00A0.
  - Required: digit 1 shows 0111111.
  - Stimulus: overflow_i=1 at a frame boundary.
  - Required: all four slots show 0111111 with dp_o=1.
- Mid-slot reset:
  - Stimulus: assert rst_i during digit 2.
  - Required: outputs go to reset values with no clock edge; after release the first slot is digit 0, SCAN_DIV edges later.
- Macro build:
  - Stimulus: digits_i=16'h0045, dp_mask_i=0.
  - Required: slots 3 and 2 keep an_o all-high with bcd_o=1111111.
  - Stimulus: digits_i=16'h0005 with dp_mask_i=4'b0010.
  - Required: digit 1 shows 0 (1000000) with dp_o=0.
